// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider with a two-byte command parser.
// One byte source is selected. Each command is a {header, divisor} byte
// pair. It programs a per-channel shadow divisor or a stop request, and
// the channel picks the new value up only at its own period boundary, so
// the divided clocks never glitch.
module clk_div_mc #(
  parameter int CH_NUM  = 4,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SEL_W-1:0]     src_sel_i,
  input  logic [NUM_SRC*8-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]   src_vld_i,
  output logic [CH_NUM-1:0]    div_clk_o,
  output logic [CH_NUM-1:0]    ch_en_o,
  output logic                 cfg_busy_o,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    WAIT_DATA
  } state_e;

  // Parser state
  state_e           state_q, state_d;
  logic [3:0]       ch_q, ch_d;
  logic             en_q, en_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SEL_W-1:0] sel_q;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             commit;

  // Per-channel state
  logic [7:0]        shadow_q [CH_NUM];
  logic [7:0]        shadow_d [CH_NUM];
  logic [7:0]        act_q    [CH_NUM];
  logic [7:0]        act_d    [CH_NUM];
  logic [7:0]        cnt_q    [CH_NUM];
  logic [7:0]        cnt_d    [CH_NUM];
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [CH_NUM-1:0] pend_en_q, pend_en_d;
  logic [CH_NUM-1:0] run_q, run_d;
  logic [CH_NUM-1:0] div_q, div_d;

  // Selected byte source
  logic       byte_vld;
  logic [7:0] byte_data;
  logic       sel_chg;
  logic       hdr_ok;

  // High phase covers counts 0 .. ceil(n/2)-1.
  function automatic logic high_at(input logic [7:0] cnt, input logic [7:0] n);
    logic [8:0] half;
    half = ({1'b0, n} + 9'd1) >> 1;
    return ({1'b0, cnt} < half);
  endfunction

  // Route the selected source to the parser; out-of-range selects match nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    byte_vld  = 1'b0;
    byte_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel_i == SEL_W'(k)) begin
        byte_vld  = src_vld_i[k];
        byte_data = src_data_i[8*k +: 8];
      end
    end
  end

  assign sel_chg = (src_sel_i != sel_q);
  assign hdr_ok  = (byte_data[7:6] == 2'b10) &&
                   ({28'd0, byte_data[3:0]} < 32'(CH_NUM));

  // Command FSM next-state: header decode, divisor commit, timeout and abort.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    en_d    = en_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (byte_vld) begin
          if (hdr_ok) begin
            ch_d    = byte_data[3:0];
            en_d    = byte_data[5];
            state_d = WAIT_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (sel_chg) begin
          // A byte arriving together with a source switch is dropped.
          err_d   = 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else if (byte_vld) begin
          if (en_q && (byte_data < 8'd2)) begin
            err_d = 1'b1;
          end else begin
            commit = 1'b1;
            done_d = 1'b1;
          end
          state_d = IDLE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
  end

  // Command FSM registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      en_q    <= 1'b0;
      tmo_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      en_q    <= en_d;
      tmo_q   <= tmo_d;
      sel_q   <= src_sel_i;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Channel dividers: count, apply pending changes at boundaries, latch commits.
  always_comb begin
    pend_d    = pend_q;
    pend_en_d = pend_en_q;
    run_d     = run_q;
    div_d     = div_q;
    for (int i = 0; i < CH_NUM; i++) begin
      shadow_d[i] = shadow_q[i];
      act_d[i]    = act_q[i];
      cnt_d[i]    = cnt_q[i];

      if (run_q[i]) begin
        if (cnt_q[i] == act_q[i] - 8'd1) begin
          cnt_d[i] = '0;
          div_d[i] = 1'b1;
          if (pend_q[i]) begin
            pend_d[i] = 1'b0;
            if (pend_en_q[i]) begin
              act_d[i] = shadow_q[i];
            end else begin
              run_d[i] = 1'b0;
              div_d[i] = 1'b0;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
          div_d[i] = high_at(cnt_q[i] + 8'd1, act_q[i]);
        end
      end else if (pend_q[i]) begin
        // A stopped channel has no phase to protect: start right away.
        pend_d[i] = 1'b0;
        if (pend_en_q[i]) begin
          act_d[i] = shadow_q[i];
          cnt_d[i] = '0;
          run_d[i] = 1'b1;
          div_d[i] = 1'b1;
        end
      end

      // A fresh commit overrides whatever was pending; the last one wins.
      if (commit && (ch_q == 4'(i))) begin
        pend_d[i]    = 1'b1;
        pend_en_d[i] = en_q;
        if (en_q) begin
          shadow_d[i] = byte_data;
        end
      end
    end
  end

  // Channel registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      pend_en_q <= '0;
      run_q     <= '0;
      div_q     <= '0;
      // NOTE: the divisor arrays are reset because a zeroed divisor is part of the defined idle state.
      for (int i = 0; i < CH_NUM; i++) begin
        shadow_q[i] <= '0;
        act_q[i]    <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      pend_q    <= pend_d;
      pend_en_q <= pend_en_d;
      run_q     <= run_d;
      div_q     <= div_d;
      for (int i = 0; i < CH_NUM; i++) begin
        shadow_q[i] <= shadow_d[i];
        act_q[i]    <= act_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign div_clk_o  = div_q;
  assign ch_en_o    = run_q;
  assign cfg_busy_o = (state_q == WAIT_DATA);
  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;

endmodule

// File: doc/clk_div_mc.md
Name: clk_div_mc

Overview:
Multi-channel programmable clock divider with a built-in byte-command parser and source selection. It takes command bytes from NUM_SRC serial receivers (UART/I2C/SPI byte outputs) and accepts only the source chosen by src_sel_i. It decodes two-byte commands, {header, divisor}, into per-channel divisor and enable settings, and drives CH_NUM independent divided clocks. Divisor changes take effect only at period boundaries, so the outputs never glitch.

Parameters:
CH_NUM, 4, number of divided-clock channels (1..16)
NUM_SRC, 3, number of byte sources (1..4)
SEL_W, 2, width of src_sel_i
TIMEOUT, 1000, clk_i cycles allowed between header and divisor byte (>=2)

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  synchronous reset, active-high
src_sel_i  input  SEL_W  selected byte source index
src_data_i  input  NUM_SRC*8  source bytes; source k on bits [8k+7:8k]
src_vld_i  input  NUM_SRC  one-cycle byte-valid pulse per source
div_clk_o  output  CH_NUM  divided clocks, registered
ch_en_o  output  CH_NUM  channel running flags
cfg_busy_o  output  1  high while a divisor byte is awaited
cfg_done_o  output  1  one-cycle pulse when a command is committed
cfg_err_o  output  1  one-cycle pulse on any rejected or aborted command

Behaviour:
- Reset, synchronous: every output is 0, every shadow/active divisor is 0, all channels are stopped, the FSM is in IDLE, and the timeout counter is 0. Reset asserted mid-operation discards any partial command and forces div_clk_o low on the next edge.
- Byte intake: a byte is accepted only when src_sel_i < NUM_SRC and src_vld_i[src_sel_i]=1. Valid pulses on unselected sources are ignored. If src_sel_i >= NUM_SRC, no byte is accepted.
- Header byte format:
  - bits [7:6] must be 2'b10.
  - bit 5 is the enable bit.
  - bit 4 is reserved and ignored.
  - bits [3:0] are the channel index.
- FSM states: IDLE, WAIT_DATA.
  - IDLE, on an accepted byte:
    - marker != 2'b10, or channel >= CH_NUM: pulse cfg_err_o on the next cycle and stay in IDLE.
    - otherwise: latch the channel and enable bit, then go to WAIT_DATA on the next cycle.
  - WAIT_DATA:
    - cfg_busy_o = 1.
    - The timeout counter increments every cycle.
    - On an accepted byte with enable=1 and divisor in {0,1}: cfg_err_o pulses and the channel is unchanged.
    - On an accepted byte otherwise: write shadow[ch] = byte and the enable request, pulse cfg_done_o on the next cycle, and return to IDLE.
    - With enable=0, the divisor byte is required but ignored; a stop request is recorded.
    - Timeout counter reaches TIMEOUT with no byte: cfg_err_o pulses and the FSM returns to IDLE.
    - src_sel_i changes value while in WAIT_DATA: abort, cfg_err_o pulses, and the FSM returns to IDLE. A byte arriving in the same cycle as the change is discarded.
  - cfg_err_o and cfg_done_o are never high in the same cycle.
- Channel divider:
  - Each channel has an 8-bit counter cnt running 0..N-1, where N is the active divisor.
  - div_clk_o = 1 while cnt < ceil(N/2), else 0. For even N the duty is exactly 50%; for odd N it is high (N+1)/2 cycles and low (N-1)/2 cycles.
  - The period boundary is the cycle with cnt == N-1.
  - Pending shadow values or stop requests are applied there: the next cycle starts cnt=0 with the new N.
- Stopped channel:
  - div_clk_o=0 and ch_en_o=0.
  - An enable command is applied on the cycle after commit, i.e. the cfg_done_o cycle.
  - div_clk_o first goes high on the cycle after that.
  - ch_en_o goes to 1 together with the first high.
- Stop request on a running channel: the current period completes, then div_clk_o is held 0 and ch_en_o drops at the boundary.
- Back-to-back commands to the same channel before its boundary: the last committed value wins.
- Commands to different channels are independent and never disturb a running channel's phase.

Test Plan:
- Reset, src_sel_i=0, src0 bytes 0xA0 then 0x04 -> cfg_done_o pulses 1 cycle after the data byte; div_clk_o[0] runs 1,1,0,0 repeating starting 2 cycles after the data byte; ch_en_o[0]=1.
- Header 0xA1 with divisor 0x05 -> div_clk_o[1] high 3 cycles, low 2 cycles, period 5; channel 0 phase is unaffected.
- Channel 0 running /4, command 0xA0,0x06 issued at cnt=1:
  - the current 4-cycle period completes, then /6 runs with pattern 111000;
  - no pulse is shorter than 2 cycles;
  - then 0x80,0x00 -> output low after the current period and ch_en_o[0]=0.
- Errors, each producing exactly one cfg_err_o pulse and no channel change:
  - header 0x40 (bad marker);
  - header 0xA5 with CH_NUM=4 (channel out of range);
  - 0xA0 followed by divisor 0x01.
- Header 0xA2, then no byte -> cfg_busy_o=1 for TIMEOUT cycles, then cfg_err_o pulses and cfg_busy_o=0; a following valid command is accepted normally.
- Header on src0, then src_sel_i switched to 1 -> abort error. Bytes on src2 while src_sel_i=1 are ignored. A full command on src1 succeeds. Setting src_sel_i=3 blocks all intake.
